// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, async-read instruction memory, IF/ID pipeline register, perf counters.
// One-cycle latency PC->IF/ID; stall holds PC and IF/ID, redirect/flush insert a bubble, reset overrides all.
module if_fetch_stage #(
    parameter int IMEM_DEPTH = 128,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      if_id_instr_o,
    output logic [31:0]      if_id_pc4_o,
    output logic             if_id_valid_o,
    output logic [CNT_W-1:0] fetch_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Loaded externally; no write port, no reset.
    reg [31:0] Instr_Mem [0:IMEM_DEPTH-1];

    logic [31:0] fetch_word;
    logic [31:0] pc_plus4;
    logic        out_of_range;

    assign pc_plus4     = pc_o + 32'd4;
    assign out_of_range = |pc_o[31:AW+2];

    // Addresses past the end of the memory fetch a NOP (all zeros).
    always_comb begin
        fetch_word = 32'h0;
        if (!out_of_range) begin
            fetch_word = Instr_Mem[pc_o[AW+1:2]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            pc_o          <= 32'h0;
            if_id_instr_o <= 32'h0;
            if_id_pc4_o   <= 32'h0;
            if_id_valid_o <= 1'b0;
            fetch_cnt_o   <= '0;
            stall_cnt_o   <= '0;
        end else begin
            if (redirect_i) begin
                pc_o <= redirect_pc_i & ~32'd3;
            end else if (!stall_i) begin
                pc_o <= pc_plus4;
            end

            // A redirect also squashes the wrong-path word fetched this cycle.
            if (flush_i || redirect_i) begin
                if_id_instr_o <= 32'h0;
                if_id_pc4_o   <= 32'h0;
                if_id_valid_o <= 1'b0;
            end else if (!stall_i) begin
                if_id_instr_o <= fetch_word;
                if_id_pc4_o   <= pc_plus4;
                if_id_valid_o <= 1'b1;
                if (fetch_cnt_o != CNT_MAX) begin
                    fetch_cnt_o <= fetch_cnt_o + CNT_ONE;
                end
            end

            // Only counts cycles where the stall actually held the PC.
            if (stall_i && !redirect_i && (stall_cnt_o != CNT_MAX)) begin
                stall_cnt_o <= stall_cnt_o + CNT_ONE;
            end
        end
    end
endmodule
